// File: rtl/nibble_sel_pkg.sv
// Nibble selector shared definitions.
// Mode encodings and default widths.
package nibble_sel_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NIB_W_DEF  = 4;
  localparam int LANES_DEF  = 4;

  typedef enum logic [1:0] {
    MODE_SELECT  = 2'd0,
    MODE_REVERSE = 2'd1,
    MODE_XOR     = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

endpackage

// File: rtl/nibble_sel_fifo.sv
// Two-entry FIFO holding computed lane words.
// Ports: clk_i, rst_i, push_i/data_i in, pop_i out, data_o/valid_o head, ready_o (registered).
module nibble_sel_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             ready_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q;
  logic             rd_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             ready_q;
  logic             push;
  logic             pop;

  // ready_q is the only push qualifier, so a full FIFO
  // never pushes even when the head pops this cycle.
  assign push    = push_i & ready_q;
  assign valid_o = (cnt_q != 2'd0);
  assign pop     = pop_i & valid_o;
  assign data_o  = mem_q[rd_q];
  assign ready_o = ready_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != 2'd2);
    end
  end

endmodule

// File: rtl/nibble_sel_pipe.sv
// Per-lane nibble selector (select/reverse/xor) feeding a 2-deep FIFO.
// Ports: valid/ready in, data/sel/mode, valid/ready out, nibble_out, xfer count, sticky err.
module nibble_sel_pipe
  import nibble_sel_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NIB_W  = NIB_W_DEF,
  parameter  int LANES  = LANES_DEF,
  localparam int NIBS   = DATA_W / NIB_W,
  localparam int IDX_W  = (NIBS > 1) ? $clog2(NIBS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      data_a_i,
  input  logic [DATA_W-1:0]      data_b_i,
  input  logic [LANES*IDX_W-1:0] sel_a_i,
  input  logic [LANES*IDX_W-1:0] sel_b_i,
  input  logic [LANES-1:0]       sel_src_i,
  input  logic [1:0]             mode_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*NIB_W-1:0] nibble_out_o,
  output logic [15:0]            xfer_cnt_o,
  output logic                   err_o,
  input  logic                   err_clr_i
);

  localparam int EXT = 1 << IDX_W;

  // Nibble tables padded to a power of two; padded
  // slots read as zero and are flagged invalid.
  logic [NIB_W-1:0] nib_a [EXT];
  logic [NIB_W-1:0] nib_b [EXT];
  logic [EXT-1:0]   idx_ok;

  for (genvar j = 0; j < EXT; j++) begin : g_nib
    if (j < NIBS) begin : g_v
      assign nib_a[j]  = data_a_i[j*NIB_W +: NIB_W];
      assign nib_b[j]  = data_b_i[j*NIB_W +: NIB_W];
      assign idx_ok[j] = 1'b1;
    end else begin : g_z
      assign nib_a[j]  = '0;
      assign nib_b[j]  = '0;
      assign idx_ok[j] = 1'b0;
    end
  end

  logic [NIB_W-1:0]       sel_l [LANES];
  logic [NIB_W-1:0]       xor_l [LANES];
  logic [IDX_W-1:0]       ia;
  logic [IDX_W-1:0]       ib;
  logic                   bad_sel;
  logic                   bad_xor;
  logic [LANES*NIB_W-1:0] res;
  logic                   bad;

  always_comb begin
    ia      = '0;
    ib      = '0;
    bad_sel = 1'b0;
    bad_xor = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      ia       = sel_a_i[i*IDX_W +: IDX_W];
      ib       = sel_b_i[i*IDX_W +: IDX_W];
      sel_l[i] = sel_src_i[i] ? nib_b[ib] : nib_a[ia];
      xor_l[i] = nib_a[ia] ^ nib_b[ib];
      bad_sel  = bad_sel |
                 (sel_src_i[i] ? ~idx_ok[ib] : ~idx_ok[ia]);
      bad_xor  = bad_xor | ~idx_ok[ia] | ~idx_ok[ib];
    end
  end

  always_comb begin
    res = '0;
    bad = 1'b0;
    unique case (mode_e'(mode_i))
      MODE_REVERSE: begin
        for (int i = 0; i < LANES; i++)
          res[i*NIB_W +: NIB_W] = sel_l[LANES-1-i];
        bad = bad_sel;
      end
      MODE_XOR: begin
        for (int i = 0; i < LANES; i++)
          res[i*NIB_W +: NIB_W] = xor_l[i];
        bad = bad_xor;
      end
      MODE_RSVD: begin
        for (int i = 0; i < LANES; i++)
          res[i*NIB_W +: NIB_W] = sel_l[i];
        bad = 1'b1;
      end
      MODE_SELECT: begin
        for (int i = 0; i < LANES; i++)
          res[i*NIB_W +: NIB_W] = sel_l[i];
        bad = bad_sel;
      end
    endcase
  end

  logic accept;
  logic out_hs;

  assign accept = in_valid_i & in_ready_o;
  assign out_hs = out_valid_o & out_ready_i;

  nibble_sel_fifo #(
    .WIDTH (LANES*NIB_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (in_valid_i),
    .pop_i   (out_ready_i),
    .data_i  (res),
    .data_o  (nibble_out_o),
    .valid_o (out_valid_o),
    .ready_o (in_ready_o)
  );

  logic [15:0] xfer_q;
  logic [15:0] xfer_d;
  logic        err_q;
  logic        err_d;

  always_comb begin
    xfer_d = out_hs ? xfer_q + 16'd1 : xfer_q;
    // A new error beats a same-cycle clear.
    if (accept && bad)
      err_d = 1'b1;
    else if (err_clr_i)
      err_d = 1'b0;
    else
      err_d = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xfer_q <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      xfer_q <= xfer_d;
      err_q  <= err_d;
    end
  end

  assign xfer_cnt_o = xfer_q;
  assign err_o      = err_q;

endmodule
